// File: rtl/video_timing_pkg.sv
// Default raster constants and shared types for the video timing blocks.
// Defaults reproduce the arcade raster: 768 half-pixel ticks per line, lines 248..511.
package video_timing_pkg;

  localparam int DEF_DIV        = 5;
  localparam int DEF_TICK_PHASE = 3;
  localparam int DEF_HW         = 10;
  localparam int DEF_VW         = 9;
  localparam int DEF_H_TOTAL    = 768;
  localparam int DEF_H_BLANK_ON = 512;
  localparam int DEF_HSYNC_ON   = 576;
  localparam int DEF_HSYNC_OFF  = 640;
  localparam int DEF_V_INC_H    = 608;
  localparam int DEF_V_FIRST    = 248;
  localparam int DEF_V_LAST     = 511;
  localparam int DEF_VBLK_ON    = 496;
  localparam int DEF_VBLK_OFF   = 256;
  localparam int DEF_VSYNC_ON   = 500;
  localparam int DEF_VSYNC_OFF  = 504;
  localparam int DEF_BLANK_DLY  = 4;

  // Wide enough for any divider up to 32 master clocks per tick.
  localparam int PHASE_W = 5;
  typedef logic [PHASE_W-1:0] vt_phase_t;

endpackage

// File: rtl/video_timing_gen_if.sv
// Control inputs and raster outputs of the timing generator, shared with the
// tile, object and palette stages.
interface video_timing_gen_if
  import video_timing_pkg::*;
#(
  parameter int HW = DEF_HW,
  parameter int VW = DEF_VW
);
  logic          flip_ena;
  logic          vblk_irq_ena;
  logic          vblk_irq_ack;
  logic          line_irq_ena;
  logic          line_irq_ack;
  logic [VW-1:0] line_cmp;

  logic          tick;
  logic [HW-1:0] htiming;
  logic [VW-1:0] vtiming;
  logic [7:0]    vtiming_f;
  logic          cpuclk;
  logic          hblk;
  logic          vblk;
  logic          cmpblk;
  logic          cmpblk_d;
  logic          hsync;
  logic          vsync;
  logic          frame_start;
  logic          vblk_irq;
  logic          line_irq;

  modport master (
    input  flip_ena, vblk_irq_ena, vblk_irq_ack, line_irq_ena, line_irq_ack, line_cmp,
    output tick, htiming, vtiming, vtiming_f, cpuclk, hblk, vblk, cmpblk, cmpblk_d,
           hsync, vsync, frame_start, vblk_irq, line_irq
  );

  modport slave (
    output flip_ena, vblk_irq_ena, vblk_irq_ack, line_irq_ena, line_irq_ack, line_cmp,
    input  tick, htiming, vtiming, vtiming_f, cpuclk, hblk, vblk, cmpblk, cmpblk_d,
           hsync, vsync, frame_start, vblk_irq, line_irq
  );

endinterface

// File: rtl/vt_irq_latch.sv
// Pending-interrupt latch: a set beats a simultaneous ack; a low enable
// clears the latch and blocks new sets.
module vt_irq_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic ack,
  input  logic ena,
  output logic pending
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pending <= 1'b0;
    else if (!ena)  pending <= 1'b0;
    else if (set)   pending <= 1'b1;
    else if (ack)   pending <= 1'b0;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: tick divider, h/v counters, registered blank/sync
// decode, delayed composite blank and the vblank/line interrupts.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int DIV        = DEF_DIV,
  parameter int TICK_PHASE = DEF_TICK_PHASE,
  parameter int HW         = DEF_HW,
  parameter int VW         = DEF_VW,
  parameter int H_TOTAL    = DEF_H_TOTAL,
  parameter int H_BLANK_ON = DEF_H_BLANK_ON,
  parameter int HSYNC_ON   = DEF_HSYNC_ON,
  parameter int HSYNC_OFF  = DEF_HSYNC_OFF,
  parameter int V_INC_H    = DEF_V_INC_H,
  parameter int V_FIRST    = DEF_V_FIRST,
  parameter int V_LAST     = DEF_V_LAST,
  parameter int VBLK_ON    = DEF_VBLK_ON,
  parameter int VBLK_OFF   = DEF_VBLK_OFF,
  parameter int VSYNC_ON   = DEF_VSYNC_ON,
  parameter int VSYNC_OFF  = DEF_VSYNC_OFF,
  parameter int BLANK_DLY  = DEF_BLANK_DLY
) (
  input  logic               clk,
  input  logic               rst_n,
  video_timing_gen_if.master bus
);

  localparam vt_phase_t     PH_TICK = vt_phase_t'(TICK_PHASE);
  localparam vt_phase_t     PH_LAST = vt_phase_t'(DIV - 1);
  localparam logic [HW-1:0] H_MAX   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VINC  = HW'(V_INC_H);
  localparam logic [HW-1:0] H_BLK   = HW'(H_BLANK_ON);
  localparam logic [HW-1:0] HS_ON   = HW'(HSYNC_ON);
  localparam logic [HW-1:0] HS_OFF  = HW'(HSYNC_OFF);
  localparam logic [VW-1:0] V_MIN   = VW'(V_FIRST);
  localparam logic [VW-1:0] V_MAX   = VW'(V_LAST);
  localparam logic [VW-1:0] VB_ON   = VW'(VBLK_ON);
  localparam logic [VW-1:0] VB_OFF  = VW'(VBLK_OFF);
  localparam logic [VW-1:0] VS_ON   = VW'(VSYNC_ON);
  localparam logic [VW-1:0] VS_OFF  = VW'(VSYNC_OFF);

  vt_phase_t     phase;
  logic          tick_en, tick_q, fs_q;
  logic [HW-1:0] h, h_next;
  logic [VW-1:0] v, v_next;
  logic          v_adv, v_wrap;
  logic          hblk_n, vblk_n;
  logic          hblk_q, vblk_q, cmpblk_q, hsync_q, vsync_q;
  logic          cmpblk_dly;
  logic          vblk_set, line_set;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value held and infer a latch.
    tick_en = (phase == PH_TICK);
    h_next  = h;
    v_next  = v;
    v_adv   = 1'b0;
    v_wrap  = 1'b0;
    if (tick_en) begin
      h_next = (h == H_MAX) ? '0 : h + 1'b1;
      if (h_next == H_VINC) begin
        v_adv  = 1'b1;
        v_wrap = (v == V_MAX);
        v_next = v_wrap ? V_MIN : v + 1'b1;
      end
    end
  end

  assign hblk_n = (h_next >= H_BLK);
  assign vblk_n = (v_next >= VB_ON) || (v_next < VB_OFF);

  // Decode from the next counter values so the flags line up with the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= '0;
      tick_q   <= 1'b0;
      h        <= '0;
      v        <= V_MIN;
      fs_q     <= 1'b0;
      hblk_q   <= 1'b0;
      vblk_q   <= 1'b1;
      cmpblk_q <= 1'b1;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
    end else begin
      phase    <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      tick_q   <= tick_en;
      h        <= h_next;
      v        <= v_next;
      fs_q     <= v_wrap;
      hblk_q   <= hblk_n;
      vblk_q   <= vblk_n;
      cmpblk_q <= hblk_n | vblk_n;
      hsync_q  <= (h_next >= HS_ON) && (h_next < HS_OFF);
      vsync_q  <= (v_next >= VS_ON) && (v_next < VS_OFF);
    end
  end

  generate
    if (BLANK_DLY == 0) begin : g_no_dly
      assign cmpblk_dly = cmpblk_q;
    end else begin : g_dly
      logic [BLANK_DLY-1:0] sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr <= '1;
        end else if (tick_en) begin
          sr[0] <= cmpblk_q;
          for (int i = 1; i < BLANK_DLY; i++) sr[i] <= sr[i-1];
        end
      end
      assign cmpblk_dly = sr[BLANK_DLY-1];
    end
  endgenerate

  assign vblk_set = tick_en & vblk_n & ~vblk_q;
  assign line_set = v_adv & (v_next == bus.line_cmp);

  vt_irq_latch u_vblk_irq (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (vblk_set),
    .ack     (bus.vblk_irq_ack),
    .ena     (bus.vblk_irq_ena),
    .pending (bus.vblk_irq)
  );

  vt_irq_latch u_line_irq (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (line_set),
    .ack     (bus.line_irq_ack),
    .ena     (bus.line_irq_ena),
    .pending (bus.line_irq)
  );

  assign bus.tick        = tick_q;
  assign bus.htiming     = h;
  assign bus.vtiming     = v;
  assign bus.vtiming_f   = v[7:0] ^ {8{bus.flip_ena}};
  assign bus.cpuclk      = h[1];
  assign bus.hblk        = hblk_q;
  assign bus.vblk        = vblk_q;
  assign bus.cmpblk      = cmpblk_q;
  assign bus.cmpblk_d    = cmpblk_dly;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a short-line raster keeps whole frames
// cheap while the vertical range, divider and blank delay stay at their defaults.
module tb_video_timing_gen;

  localparam int DIV = 5, TP = 3, HT = 10, HB = 6, HS_ON = 7, HS_OFF = 9, VI = 8;
  localparam int VF = 248, VL = 511, VB_ON = 496, VB_OFF = 256, VS_ON = 500, VS_OFF = 504;
  localparam int BD = 4;
  localparam int NL = VL - VF + 1;
  localparam int LIMIT = 20000;

  typedef struct packed {
    logic       tick;
    logic [9:0] h;
    logic [8:0] v;
    logic [7:0] vf;
    logic       cpuclk, hblk, vblk, cmpblk, cmpblk_d, hsync, vsync, fs, virq, lirq;
  } obs_t;

  typedef enum {W_LIRQ, W_VIRQ, W_V300, W_VSET_NEXT, W_F2_V501, W_F3_V400} wait_e;

  logic   clk = 1'b0;
  logic   rst_n;
  int     errors = 0;
  int     checks = 0;
  int     fs_seen = 0;
  longint n = 0;
  bit     running = 1'b0;
  logic   m_virq = 1'b0, m_lirq = 1'b0;
  obs_t   q[$];

  always #5 clk = ~clk;

  video_timing_gen_if #(.HW(10), .VW(9)) bus ();

  video_timing_gen #(
    .DIV(DIV), .TICK_PHASE(TP), .HW(10), .VW(9), .H_TOTAL(HT), .H_BLANK_ON(HB),
    .HSYNC_ON(HS_ON), .HSYNC_OFF(HS_OFF), .V_INC_H(VI), .V_FIRST(VF), .V_LAST(VL),
    .VBLK_ON(VB_ON), .VBLK_OFF(VB_OFF), .VSYNC_ON(VS_ON), .VSYNC_OFF(VS_OFF),
    .BLANK_DLY(BD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic finish_bench();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Closed-form raster after k clock edges since reset release.
  function automatic longint ticks_at(input longint k);
    return (k + DIV - TP - 1) / DIV;
  endfunction

  function automatic bit tick_at(input longint k);
    return (k >= 1) && (((k - 1) % DIV) == TP);
  endfunction

  function automatic void raster(input longint t, output int h, output int v, output longint a);
    h = int'(t % HT);
    a = (t + HT - VI) / HT;
    v = VF + int'(a % NL);
  endfunction

  function automatic bit cmpblk_of(input longint t);
    int h, v;
    longint a;
    if (t < 0) return 1'b1;
    raster(t, h, v, a);
    return (h >= HB) || (v >= VB_ON) || (v < VB_OFF);
  endfunction

  function automatic obs_t expect_at(input longint k);
    obs_t e;
    int h, v;
    longint a, t;
    t = ticks_at(k);
    raster(t, h, v, a);
    e.tick     = tick_at(k);
    e.h        = 10'(h);
    e.v        = 9'(v);
    e.vf       = '0;
    e.cpuclk   = e.h[1];
    e.hblk     = (h >= HB);
    e.vblk     = (v >= VB_ON) || (v < VB_OFF);
    e.cmpblk   = e.hblk | e.vblk;
    e.cmpblk_d = cmpblk_of(t - BD);
    e.hsync    = (h >= HS_ON) && (h < HS_OFF);
    e.vsync    = (v >= VS_ON) && (v < VS_OFF);
    e.fs       = e.tick && (h == VI) && (v == VF) && (a > 0);
    e.virq     = m_virq;
    e.lirq     = m_lirq;
    return e;
  endfunction

  function automatic obs_t reset_exp();
    obs_t e;
    e          = '0;
    e.v        = 9'(VF);
    e.vf       = e.v[7:0] ^ {8{bus.flip_ena}};
    e.vblk     = 1'b1;
    e.cmpblk   = 1'b1;
    e.cmpblk_d = 1'b1;
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.tick     = bus.tick;
    o.h        = bus.htiming;
    o.v        = bus.vtiming;
    o.vf       = bus.vtiming_f;
    o.cpuclk   = bus.cpuclk;
    o.hblk     = bus.hblk;
    o.vblk     = bus.vblk;
    o.cmpblk   = bus.cmpblk;
    o.cmpblk_d = bus.cmpblk_d;
    o.hsync    = bus.hsync;
    o.vsync    = bus.vsync;
    o.fs       = bus.frame_start;
    o.virq     = bus.vblk_irq;
    o.lirq     = bus.line_irq;
    return o;
  endfunction

  // One clock: update the interrupt model from the inputs sampled at the edge,
  // drop one-shot acks, then queue the expected outputs for this cycle.
  task automatic step();
    logic vack, lack, vena, lena;
    logic [8:0] lc;
    int h, v;
    longint a;
    bit tk, vset, lset;
    @(posedge clk);
    vack = bus.vblk_irq_ack;
    lack = bus.line_irq_ack;
    vena = bus.vblk_irq_ena;
    lena = bus.line_irq_ena;
    lc   = bus.line_cmp;
    if (running) begin
      n++;
      raster(ticks_at(n), h, v, a);
      tk   = tick_at(n);
      vset = tk && (h == VI) && (v == VB_ON);
      lset = tk && (h == VI) && (v == int'(lc));
      if (!vena)      m_virq = 1'b0;
      else if (vset)  m_virq = 1'b1;
      else if (vack)  m_virq = 1'b0;
      if (!lena)      m_lirq = 1'b0;
      else if (lset)  m_lirq = 1'b1;
      else if (lack)  m_lirq = 1'b0;
    end
    #1;
    bus.vblk_irq_ack = 1'b0;
    bus.line_irq_ack = 1'b0;
    if (running) q.push_back(expect_at(n));
    if (errors >= 20) finish_bench();
  endtask

  function automatic bit reached(input wait_e w);
    int h, v;
    longint a;
    raster(ticks_at(n), h, v, a);
    case (w)
      W_LIRQ:      return m_lirq;
      W_VIRQ:      return m_virq;
      W_V300:      return v == 300;
      W_VSET_NEXT: begin
        raster(ticks_at(n + 1), h, v, a);
        return tick_at(n + 1) && (h == VI) && (v == VB_ON);
      end
      W_F2_V501:   return (a / NL == 2) && (v == 501);
      W_F3_V400:   return (a / NL == 3) && (v == 400) && (h == 5);
      default:     return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input wait_e w);
    int g = 0;
    while (!reached(w) && g < LIMIT) begin
      step();
      g++;
    end
    check(tag, reached(w), 1);
  endtask

  always @(negedge clk) begin : monitor
    obs_t e;
    if (q.size() > 0) begin
      e    = q.pop_front();
      e.vf = e.v[7:0] ^ {8{bus.flip_ena}};
      check("raster", observe(), e);
    end
    if (running && bus.frame_start) fs_seen++;
  end

  initial begin
    rst_n            = 1'b0;
    bus.flip_ena     = 1'b0;
    bus.vblk_irq_ena = 1'b0;
    bus.vblk_irq_ack = 1'b0;
    bus.line_irq_ena = 1'b0;
    bus.line_irq_ack = 1'b0;
    bus.line_cmp     = 9'd300;
    repeat (3) step();
    check("reset_state", observe(), reset_exp());

    rst_n   = 1'b1;
    running = 1'b1;
    q.push_back(expect_at(0));
    bus.vblk_irq_ena = 1'b1;
    bus.line_irq_ena = 1'b1;
    repeat (TP) step();
    check("tick_before_first", bus.tick, 0);
    step();
    check("first_tick", bus.tick, 1);
    check("first_htiming", bus.htiming, 1);

    wait_for("line_irq_wait", W_LIRQ);
    check("line_irq_vtiming", bus.vtiming, 300);
    check("line_irq_level", bus.line_irq, 1);
    bus.line_irq_ack = 1'b1;
    step();
    check("line_irq_ack", bus.line_irq, 0);
    bus.line_cmp = 9'd100;

    wait_for("vblk_irq_wait", W_VIRQ);
    check("vblk_irq_vtiming", bus.vtiming, 496);
    check("vblk_irq_level", bus.vblk_irq, 1);
    repeat (20) step();
    bus.vblk_irq_ack = 1'b1;
    step();
    check("vblk_irq_ack", bus.vblk_irq, 0);
    bus.vblk_irq_ack = 1'b1;
    step();
    check("ack_idle", bus.vblk_irq, 0);

    bus.flip_ena = 1'b1;
    wait_for("v300_wait", W_V300);
    check("vtiming_f_flip", bus.vtiming_f, 8'hD3);

    wait_for("vset_wait", W_VSET_NEXT);
    bus.vblk_irq_ack = 1'b1;
    step();
    check("set_beats_ack", bus.vblk_irq, 1);
    bus.vblk_irq_ena = 1'b0;
    step();
    check("ena_low_clears", bus.vblk_irq, 0);

    wait_for("frame2_wait", W_F2_V501);
    check("no_vblk_irq", bus.vblk_irq, 0);
    check("no_line_irq_100", bus.line_irq, 0);
    check("frame_starts", fs_seen, 2);

    wait_for("frame3_wait", W_F3_V400);
    q.delete();
    rst_n = 1'b0;
    #1;
    check("async_reset", observe(), reset_exp());
    running = 1'b0;
    m_virq  = 1'b0;
    m_lirq  = 1'b0;
    repeat (2) step();

    rst_n   = 1'b1;
    n       = 0;
    running = 1'b1;
    q.push_back(expect_at(0));
    check("restart_h", bus.htiming, 0);
    check("restart_v", bus.vtiming, VF);
    repeat (200) step();
    check("restart_v_after", bus.vtiming, 252);

    @(negedge clk);
    #1;
    finish_bench();
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the video subsystem. It divides the master clock into a timing tick and runs the horizontal and vertical counters. From those it decodes blanking, sync and flip-adjusted line numbers, and it raises acknowledged vertical-blank and raster-line interrupts toward the Z80 side. With default parameters it reproduces the arcade-board raster: 61.44 MHz master clock, 768 half-pixel ticks per line, lines 248..511. The tile, object and palette stages consume its outputs.

## Interface
- DIV, 5: master clocks per timing tick (≥2)
- TICK_PHASE, 3: divider phase on which tick fires (<DIV)
- HW, 10: htiming width
- VW, 9: vtiming width
- H_TOTAL, 768: ticks per line
- H_BLANK_ON, 512: first hblank tick
- HSYNC_ON / HSYNC_OFF, 576 / 640: hsync window [on, off)
- V_INC_H, 608: htiming value at which vtiming advances
- V_FIRST / V_LAST, 248 / 511: vtiming range
- VBLK_ON / VBLK_OFF, 496 / 256: vblank when v ≥ VBLK_ON or v < VBLK_OFF
- VSYNC_ON / VSYNC_OFF, 500 / 504: vsync window [on, off)
- BLANK_DLY, 4: cmpblk_d delay in ticks (0..15)
- clk  in  1  master clock
- rst_n  in  1  asynchronous, active-low reset
- flip_ena  in  1  screen flip
- vblk_irq_ena  in  1  vblank interrupt enable; low clears pending
- vblk_irq_ack  in  1  one-clk acknowledge
- line_irq_ena  in  1  line interrupt enable; low clears pending
- line_irq_ack  in  1  one-clk acknowledge
- line_cmp  in  VW  line-compare value
- tick  out  1  one-clk timing-tick strobe
- htiming  out  HW  horizontal count
- vtiming  out  VW  vertical count
- vtiming_f  out  8  vtiming[7:0] XOR {8{flip_ena}} (combinational)
- cpuclk  out  1  htiming[1]
- hblk, vblk, cmpblk  out  1  blanks; cmpblk = hblk|vblk
- cmpblk_d  out  1  cmpblk delayed BLANK_DLY ticks
- hsync, vsync  out  1  active-high syncs
- frame_start  out  1  one-clk pulse when vtiming wraps to V_FIRST
- vblk_irq, line_irq  out  1  pending interrupt levels

## Operation
- Divider: phase counts 0..DIV-1 and wraps. tick = (phase == TICK_PHASE).
- On each tick, htiming increments. At H_TOTAL-1 it wraps to 0.
- On the tick where htiming becomes V_INC_H, vtiming increments. At V_LAST it wraps to V_FIRST and frame_start pulses.
- hblk, vblk, hsync, vsync and cmpblk are registered from the next counter values, so they are aligned with the counters.
- cmpblk_d uses a tick-enabled shift register. With BLANK_DLY=0 it equals cmpblk.
- vblk_irq sets on the tick where vblk rises, if vblk_irq_ena is high.
- line_irq sets on the tick where vtiming becomes line_cmp, if line_irq_ena is high. A line_cmp outside V_FIRST..V_LAST never fires.
- Each interrupt clears on its ack, or while its enable is low.
- Set and ack in the same clk: set wins and the interrupt stays pending.
- Ack with nothing pending: no effect.
- A line_cmp change mid-line takes effect at the next vtiming advance.

## Timing
- Reset values:
  - phase 0, htiming 0, vtiming V_FIRST.
  - hblk 0, vblk 1, cmpblk 1, cmpblk_d 1 (all stages).
  - hsync 0, vsync 0, tick 0, frame_start 0, both irqs 0.
- Reset mid-frame aborts immediately. The first tick after release occurs TICK_PHASE+1 clks after release.
- Tick period is DIV clks. A default line is 3840 clks; a default frame is 264 lines.
- Interrupt latency: pending is visible 1 clk after the setting tick edge. Clear is visible 1 clk after the ack edge.

## Structure
- `video_timing_pkg` holds the default raster constants (H_TOTAL, V_FIRST, V_LAST, blank and sync windows) and the `vt_phase_t` typedef. Sibling video blocks share these.
- One sub-module, `vt_irq_latch` (set, ack, ena → pending, with set priority), instantiated twice.
- Top level: divider, counters, decode registers, delay line.

## Test plan
- Defaults, release reset: tick every 5 clks; htiming 767→0; vtiming 248 at start; vtiming increments when htiming hits 608; 511→248 with a single frame_start pulse; frame = 264×3840 clks.
- Blank decode: hblk high for htiming 512..767. vblk high for v 496..511 and 248..255, low for 256..495. cmpblk_d follows cmpblk exactly 4 ticks later.
- vblk_irq: enable high; irq rises at v=496; hold ack at the same clk as the next frame's set → stays 1; a lone ack → 0; enable low → cleared and no set.
- line_irq: line_cmp=300 → irq when vtiming becomes 300; line_cmp=100 → never fires over 2 frames.
- flip_ena=1 with v=300 (low byte 0x2C) → vtiming_f=0xD3. cpuclk toggles every 2 ticks.
- Assert rst_n low mid-line at v=400, h=200 → all outputs at reset values asynchronously. After release, the counters restart from 0/248.
